// File: rtl/regfile_seq_pkg.sv
// Shared types and default widths for the register-file sequencer.
package regfile_seq_pkg;

    localparam int SEQ_DATA_WIDTH = 32;
    localparam int SEQ_IDX_WIDTH  = 2;
    localparam int SEQ_IMM_WIDTH  = 16;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_LDI = 2'b10,
        OP_AND = 2'b11
    } opcode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_READ = 2'b01,
        S_EXEC = 2'b10,
        S_WB   = 2'b11
    } state_t;

endpackage

// File: rtl/regfile_sequencer_if.sv
// Instruction handshake plus register-file read/write ports of the sequencer.
interface regfile_sequencer_if #(
    parameter int DATA_WIDTH = regfile_seq_pkg::SEQ_DATA_WIDTH,
    parameter int IDX_WIDTH  = regfile_seq_pkg::SEQ_IDX_WIDTH,
    parameter int IMM_WIDTH  = regfile_seq_pkg::SEQ_IMM_WIDTH
);
    logic                  instr_valid;
    logic                  instr_ready;
    logic [1:0]            instr_op;
    logic [IDX_WIDTH-1:0]  instr_rd;
    logic [IDX_WIDTH-1:0]  instr_ra;
    logic [IDX_WIDTH-1:0]  instr_rb;
    logic [IMM_WIDTH-1:0]  instr_imm;
    logic [IDX_WIDTH-1:0]  read_a_index;
    logic [DATA_WIDTH-1:0] read_a_data;
    logic [IDX_WIDTH-1:0]  read_b_index;
    logic [DATA_WIDTH-1:0] read_b_data;
    logic                  write_enable;
    logic [IDX_WIDTH-1:0]  write_index;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;

    modport master (
        input  instr_valid, instr_op, instr_rd, instr_ra, instr_rb, instr_imm,
        input  read_a_data, read_b_data,
        output instr_ready, read_a_index, read_b_index,
        output write_enable, write_index, write_data, done, result
    );

    modport slave (
        output instr_valid, instr_op, instr_rd, instr_ra, instr_rb, instr_imm,
        output read_a_data, read_b_data,
        input  instr_ready, read_a_index, read_b_index,
        input  write_enable, write_index, write_data, done, result
    );

endinterface

// File: rtl/regfile_seq_alu.sv
// Combinational execute unit: ADD/SUB/AND on operands, LDI passes the zero-extended immediate.
module regfile_seq_alu
    import regfile_seq_pkg::*;
#(
    parameter int DATA_WIDTH = SEQ_DATA_WIDTH,
    parameter int IMM_WIDTH  = SEQ_IMM_WIDTH
) (
    input  opcode_t               op,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    input  logic [IMM_WIDTH-1:0]  imm,
    output logic [DATA_WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        unique case (op)
            OP_ADD: result = op_a + op_b;
            OP_SUB: result = op_a - op_b;
            OP_LDI: result = DATA_WIDTH'(imm);
            OP_AND: result = op_a & op_b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/regfile_sequencer.sv
// Register-file sequencer: accepts one instruction, reads operands, executes, writes back.
// States: IDLE | waiting for an instruction; READ | indices on read ports, operands captured
//         EXEC | result register loaded;      WB   | write port driven, done pulses, may accept
module regfile_sequencer
    import regfile_seq_pkg::*;
#(
    parameter int DATA_WIDTH = SEQ_DATA_WIDTH,
    parameter int IDX_WIDTH  = SEQ_IDX_WIDTH,
    parameter int IMM_WIDTH  = SEQ_IMM_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    regfile_sequencer_if.master bus
);

    state_t                state, state_nxt;
    opcode_t               op_q;
    logic [IDX_WIDTH-1:0]  rd_q, ra_q, rb_q, wr_idx_q;
    logic [IMM_WIDTH-1:0]  imm_q;
    logic [DATA_WIDTH-1:0] op_a, op_b, result_q, alu_out;
    logic                  ready, accept;

    assign accept = bus.instr_valid && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        ready            = 1'b0;
        bus.read_a_index = '0;
        bus.read_b_index = '0;
        bus.write_enable = 1'b0;
        bus.done         = 1'b0;
        unique case (state)
            S_IDLE: begin
                ready = rst_n;
                if (accept) state_nxt = S_READ;
            end
            S_READ: begin
                bus.read_a_index = ra_q;
                bus.read_b_index = rb_q;
                state_nxt        = S_EXEC;
            end
            S_EXEC: state_nxt = S_WB;
            S_WB: begin
                ready            = rst_n;
                bus.done         = 1'b1;
                bus.write_enable = (wr_idx_q != '0);
                state_nxt        = accept ? S_READ : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.instr_ready = ready;
    assign bus.write_index = wr_idx_q;
    assign bus.write_data  = result_q;
    assign bus.result      = result_q;

    // write_index/result are loaded together in EXEC so both hold stable until the next done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_ADD;
            rd_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            imm_q    <= '0;
            op_a     <= '0;
            op_b     <= '0;
            result_q <= '0;
            wr_idx_q <= '0;
        end else begin
            if (accept) begin
                op_q  <= opcode_t'(bus.instr_op);
                rd_q  <= bus.instr_rd;
                ra_q  <= bus.instr_ra;
                rb_q  <= bus.instr_rb;
                imm_q <= bus.instr_imm;
            end
            if (state == S_READ) begin
                op_a <= bus.read_a_data;
                op_b <= bus.read_b_data;
            end
            if (state == S_EXEC) begin
                result_q <= alu_out;
                wr_idx_q <= rd_q;
            end
        end
    end

    regfile_seq_alu #(
        .DATA_WIDTH (DATA_WIDTH),
        .IMM_WIDTH  (IMM_WIDTH)
    ) u_alu (
        .op     (op_q),
        .op_a   (op_a),
        .op_b   (op_b),
        .imm    (imm_q),
        .result (alu_out)
    );

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
Initiator-side controller for the 4-entry, 32-bit, 2R1W register file. It accepts one small instruction at a time over a valid/ready handshake and drives the register file's read indices. It captures the returned operands, computes a result, and drives the write port to write the result back. It is the block that sits between an instruction source (testbench or future fetch stage) and the register file.

Parameters:
DATA_WIDTH, 32, register/operand width; matches register file data ports
IDX_WIDTH, 2, register index width; 2^IDX_WIDTH registers, index 0 reads as zero
IMM_WIDTH, 16, immediate field width; zero-extended to DATA_WIDTH

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
instr_valid  input  1  instruction offered this cycle
instr_ready  output  1  sequencer can accept an instruction
instr_op  input  2  opcode: 00 ADD, 01 SUB, 10 LDI, 11 AND
instr_rd  input  IDX_WIDTH  destination index
instr_ra  input  IDX_WIDTH  source A index
instr_rb  input  IDX_WIDTH  source B index
instr_imm  input  IMM_WIDTH  immediate for LDI
read_a_index  output  IDX_WIDTH  to register file
read_a_data  input  DATA_WIDTH  from register file (combinational read)
read_b_index  output  IDX_WIDTH  to register file
read_b_data  input  DATA_WIDTH  from register file
write_enable  output  1  to register file
write_index  output  IDX_WIDTH  to register file
write_data  output  DATA_WIDTH  to register file
done  output  1  one-cycle pulse at writeback
result  output  DATA_WIDTH  value written; held until next done

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- While rst_n=0, the following hold:
  - FSM is in IDLE.
  - write_enable=0, done=0 and instr_ready=0.
  - All index outputs, write_data, result and internal operand registers are 0.
- FSM states: IDLE, READ, EXEC, WB.
- Handshake:
  - instr_ready = rst_n AND (state==IDLE OR state==WB), combinational.
  - An instruction is accepted when instr_valid AND instr_ready are both high at a rising edge.
  - On acceptance, op/rd/ra/rb/imm are latched and the next state is READ.
  - instr_valid without instr_ready is ignored; the source must hold the instruction.
- IDLE: read indices are driven to 0. On accept, go to READ; otherwise stay in IDLE.
- READ (1 cycle):
  - read_a_index=latched ra and read_b_index=latched rb.
  - read_a_data/read_b_data are registered into op_a/op_b at the closing edge.
  - Next state is EXEC.
- EXEC (1 cycle): the result register is loaded. Next state is WB.
  - ADD: op_a+op_b.
  - SUB: op_a-op_b.
  - LDI: zero-extended imm.
  - AND: op_a&op_b.
  - Arithmetic is modulo 2^DATA_WIDTH; carry/borrow are discarded (e.g. 0xFFFFFFFF+1=0, 0-1=0xFFFFFFFF).
- WB (1 cycle):
  - write_index=rd, write_data=result, done=1.
  - write_enable=1 unless rd==0. With rd==0 there is no write, but done still pulses.
  - Next state is READ if a new instruction is accepted this cycle, otherwise IDLE.
- Latency: 3 cycles from the accept edge to the write edge. Maximum throughput is one instruction per 3 cycles (back-to-back accept in WB).
- Back-to-back dependency: an instruction accepted in WB reads in the following READ cycle, after the write has been committed. It therefore sees the new value; no forwarding is required.
- Outside WB: write_enable=0, done=0. write_index/write_data hold the last values (don't-care for the register file).
- Reset mid-operation:
  - The in-flight instruction is discarded and outputs go immediately to reset values (asynchronous).
  - No partial write occurs after rst_n falls.
  - After rst_n rises, the first edge sees IDLE with instr_ready=1.

Decomposition:
- Shared package regfile_seq_pkg holds:
  - opcode enum (OP_ADD=2'b00, OP_SUB=2'b01, OP_LDI=2'b10, OP_AND=2'b11).
  - FSM state enum.
- One sub-module, regfile_seq_alu: purely combinational, taking op, op_a, op_b and imm and producing a DATA_WIDTH result.
- The top level holds the FSM, latches and register-file port drive.
- The bench connects the sequencer to the existing register file.

Test Plan:
- LDI rd=1 imm=0x1234, then LDI rd=2 imm=0x0005, then ADD rd=3 ra=1 rb=2 -> reg3=0x00001239; done pulses 3 cycles after each accept; result=0x1239.
- With reg1=0, reg2=1, issue SUB rd=1 ra=1 rb=2 -> reg1=0xFFFFFFFF. Then LDI rd=2 imm=0xFFFF; ADD rd=3 ra=1 rb=3 is not used. Instead, ADD rd=2 ra=1 rb=1 -> 0xFFFFFFFE (wrap).
- LDI rd=0 imm=0x00AA -> done=1, result=0xAA, write_enable stays 0; a subsequent ADD rd=1 ra=0 rb=0 writes 0.
- Hold instr_valid high continuously with LDI rd=1 imm=7 followed by ADD rd=2 ra=1 rb=1 -> second instruction accepted in the WB cycle of the first; reg2=14; instr_ready low in READ/EXEC.
- Assert rst_n=0 during EXEC of AND rd=3 ra=1 rb=2 -> write_enable, done and instr_ready drop immediately; reg3 unchanged; after release, instr_ready=1 and a fresh instruction completes normally.
